// File: rtl/q2_mem_responder.sv
// q2_mem_responder
//   Memory-side responder for the Q2 CPU bus. It holds a 2^AW x DW word RAM
//   and answers the CPU's rdm/wrm strobes on abus/dbus. Reads return data
//   WAIT_STATES+1 clocks after the rdm rise. Writes commit on the wrm fall.
//
// Parameters
//   AW          address width, RAM depth is 2^AW words
//   DW          data width
//   WAIT_STATES clocks from read detect to dbus driven (0..15)
//   INIT_FILE   memory image name; the RAM is cleared to zero at time 0
//
// Ports
//   clk       system clock, all state on posedge
//   rst       synchronous reset, active low
//   abus      address from the CPU
//   dbus      shared data bus, driven only while returning read data
//   rdm       CPU read strobe, active high
//   wrm       CPU write strobe, active high
//   rd_valid  high while dbus carries valid read data
//   bus_err   sticky flag, rdm and wrm were seen high in the same cycle
//   tx_data   console byte (Q2_MEM_CONSOLE_EN only)
//   tx_valid  console byte valid (Q2_MEM_CONSOLE_EN only)
//   tx_ready  console sink accepts the byte (Q2_MEM_CONSOLE_EN only)
//
// Configuration
//   Q2_MEM_CONSOLE_EN  when defined, the top address is a console port
//                      instead of RAM.

module q2_mem_responder #(
  parameter int    AW          = 12,
  parameter int    DW          = 12,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] abus,
  inout  logic [DW-1:0] dbus,
  input  logic          rdm,
  input  logic          wrm,
  output logic          rd_valid,
  output logic          bus_err
`ifdef Q2_MEM_CONSOLE_EN
  ,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t        state, state_d;
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  logic          rdm_q, wrm_q;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q, rd_addr;
  logic [DW-1:0] wdata_q, rdata, rd_word;
  logic          drive;
  logic          start_rd, load_rd, bypass, cnt_dec, capture_wr, commit, set_err;
  logic          wr_console;

`ifdef Q2_MEM_CONSOLE_EN
  localparam logic [AW-1:0] TOP_ADDR = '1;
  assign wr_console = (addr_q == TOP_ADDR);
`else
  assign wr_console = 1'b0;
`endif

  // The bus is never driven while the CPU is writing, even if a write
  // strobe arrives in the middle of a read.
  assign drive    = (state == RD_DRIVE) && !wrm;
  assign rd_valid = drive;
  assign dbus     = drive ? rdata : {DW{1'bz}};

  // Read data source. A read starting on the same edge that commits a
  // write to the same address takes the write data directly.
  always_comb begin
    rd_word = mem[rd_addr];
`ifdef Q2_MEM_CONSOLE_EN
    if (rd_addr == TOP_ADDR) rd_word = {{(DW-1){1'b0}}, ~tx_valid};
`endif
    if (bypass) rd_word = wdata_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state logic and datapath controls. A simultaneous rdm and wrm
  // overrides everything and returns the FSM to IDLE without a RAM write.
  always_comb begin
    state_d    = state;
    start_rd   = 1'b0;
    load_rd    = 1'b0;
    rd_addr    = addr_q;
    bypass     = 1'b0;
    cnt_dec    = 1'b0;
    capture_wr = 1'b0;
    commit     = 1'b0;
    set_err    = 1'b0;
    if (rdm && wrm) begin
      set_err = 1'b1;
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rdm && !rdm_q) begin
            start_rd = 1'b1;
            rd_addr  = abus;
            if (WAIT_STATES == 0) begin
              load_rd = 1'b1;
              state_d = RD_DRIVE;
            end else begin
              state_d = RD_WAIT;
            end
          end else if (wrm && !wrm_q) begin
            capture_wr = 1'b1;
            state_d    = WR_HOLD;
          end
        end
        RD_WAIT: begin
          if (!rdm) begin
            state_d = IDLE;
          end else if (cnt == 4'd1) begin
            load_rd = 1'b1;
            state_d = RD_DRIVE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RD_DRIVE: begin
          if (!rdm) state_d = IDLE;
        end
        WR_HOLD: begin
          if (wrm) begin
            capture_wr = 1'b1;
          end else begin
            commit  = 1'b1;
            state_d = IDLE;
            // A read strobe rising as the write strobe falls starts a read
            // right away instead of being lost.
            if (rdm) begin
              start_rd = 1'b1;
              rd_addr  = abus;
              bypass   = (abus == addr_q) && !wr_console;
              if (WAIT_STATES == 0) begin
                load_rd = 1'b1;
                state_d = RD_DRIVE;
              end else begin
                state_d = RD_WAIT;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobe history keeps sampling through reset, so a strobe held across
  // reset does not look like a new rise afterwards.
  always_ff @(posedge clk) begin
    rdm_q <= rdm;
    wrm_q <= wrm;
    if (!rst) begin
      cnt     <= 4'd0;
      bus_err <= 1'b0;
    end else begin
      if (set_err) bus_err <= 1'b1;
      if (start_rd) begin
        addr_q <= abus;
        cnt    <= WAIT_INIT;
      end else if (cnt_dec) begin
        cnt <= cnt - 4'd1;
      end
      if (capture_wr) begin
        addr_q  <= abus;
        wdata_q <= dbus;
      end
      if (load_rd) rdata <= rd_word;
    end
  end

  // The RAM is not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && commit && !wr_console) mem[addr_q] <= wdata_q;
  end

`ifdef Q2_MEM_CONSOLE_EN
  // Console port. A byte written while the previous one is still pending
  // is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (commit && wr_console && !tx_valid) begin
        tx_data  <= wdata_q[7:0];
        tx_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
